// File: rtl/led_frame_sched.sv
// Frame scheduler: pops one byte per LED zone from the FIFO into a shadow frame,
// then commits the complete frame to the driver bus only between driver scans.
module led_frame_sched #(
   parameter int N_LED   = 40,
   parameter int DW      = 8,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fifo_empty,
   input  logic [DW-1:0]                    fifo_dout,
   output logic                             fifo_rd_en,
   input  logic                             drv_busy,
   output logic [N_LED*DW-1:0]              frame_data,
   output logic                             frame_upd,
   output logic                             frame_abort,
   output logic [$clog2(N_LED)-1:0]         led_idx,
   output logic [CNT_W-1:0]                 frame_cnt
);
   // state | meaning
   // FILL  | waiting for a byte; counts underrun idle cycles mid-frame
   // RD    | pop strobe out to the FIFO
   // CAP   | FIFO data valid, captured into shadow zone led_idx
   // WAIT  | shadow frame complete, held until the driver is between scans
   localparam int IW = $clog2(N_LED);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {FILL, RD, CAP, WAIT} state_t;

   state_t               state, state_nx;
   logic [IW-1:0]        idx_nx;
   logic [TW-1:0]        tmo, tmo_nx;
   logic [N_LED*DW-1:0]  shadow;
   logic                 cap, commit, abort_nx;

   always_comb begin
      state_nx = state;
      idx_nx   = led_idx;
      tmo_nx   = tmo;
      abort_nx = 1'b0;
      commit   = 1'b0;
      cap      = 1'b0;
      case (state)
         FILL: begin
            if (!fifo_empty) begin
               state_nx = RD;
            end else if (led_idx != '0) begin
               if (tmo == TW'(TIMEOUT - 1)) begin
                  abort_nx = 1'b1;
                  idx_nx   = '0;
                  tmo_nx   = '0;
               end else begin
                  tmo_nx = tmo + 1'b1;
               end
            end else begin
               tmo_nx = '0;
            end
         end
         RD: begin
            tmo_nx   = '0;
            state_nx = CAP;
         end
         CAP: begin
            cap = 1'b1;
            if (led_idx == IW'(N_LED - 1)) begin
               idx_nx   = '0;
               state_nx = WAIT;
            end else begin
               idx_nx   = led_idx + 1'b1;
               state_nx = FILL;
            end
         end
         WAIT: begin
            if (!drv_busy) begin
               commit   = 1'b1;
               state_nx = FILL;
            end
         end
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FILL;
         led_idx     <= '0;
         tmo         <= '0;
         shadow      <= '0;
         fifo_rd_en  <= 1'b0;
         frame_data  <= '0;
         frame_upd   <= 1'b0;
         frame_abort <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nx;
         led_idx     <= idx_nx;
         tmo         <= tmo_nx;
         // Strobe is registered from the next state so it is high exactly during RD.
         fifo_rd_en  <= (state_nx == RD);
         frame_upd   <= commit;
         frame_abort <= abort_nx;
         for (int k = 0; k < N_LED; k++) begin
            if (cap && led_idx == IW'(k)) shadow[k*DW +: DW] <= fifo_dout;
         end
         if (commit) begin
            frame_data <= shadow;
            frame_cnt  <= frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_led_frame_sched.sv
// Scoreboard bench for led_frame_sched: a FIFO model feeds the DUT, expected frames
// and aborts are queued at stimulus time and popped by a monitor on frame_upd/frame_abort.
module tb_led_frame_sched;
   localparam int N_LED   = 40;
   localparam int DW      = 8;
   localparam int TIMEOUT = 1024;
   localparam int CNT_W   = 2;
   localparam int IW      = $clog2(N_LED);

   typedef struct {
      logic [N_LED*DW-1:0] data;
      logic [CNT_W-1:0]    cnt;
   } frame_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 fifo_empty;
   logic [DW-1:0]        fifo_dout;
   logic                 fifo_rd_en;
   logic                 drv_busy;
   logic [N_LED*DW-1:0]  frame_data;
   logic                 frame_upd;
   logic                 frame_abort;
   logic [IW-1:0]        led_idx;
   logic [CNT_W-1:0]     frame_cnt;

   led_frame_sched #(.N_LED(N_LED), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .drv_busy(drv_busy), .frame_data(frame_data),
      .frame_upd(frame_upd), .frame_abort(frame_abort), .led_idx(led_idx),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // FIFO model: main process writes, pop process advances rd_ptr.
   logic [DW-1:0] mem [0:2047];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic empty_at_edge = 1'b1;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      empty_at_edge <= fifo_empty;
      if (fifo_rd_en && !fifo_empty) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   frame_t exp_q[$];
   int     abort_q[$];
   logic [N_LED*DW-1:0] last_frame = '0;
   logic [CNT_W-1:0]    exp_cnt = '0;

   int rd_cnt = 0, upd_cnt = 0, abort_cnt = 0;
   int rule_viol = 0;
   logic prev_rd = 1'b0;

   task automatic chk(input string name, input logic [N_LED*DW-1:0] act, input logic [N_LED*DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (fifo_rd_en) rd_cnt++;
         if (fifo_rd_en && (prev_rd || empty_at_edge)) rule_viol++;
         if (frame_upd && frame_abort) rule_viol++;
         if (frame_upd) begin
            upd_cnt++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_upd: got frame_upd=1, expected no commit");
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               chk("frame_data", frame_data, e.data);
               chk("frame_cnt", N_LED*DW'(frame_cnt), N_LED*DW'(e.cnt));
               last_frame = e.data;
            end
         end
         if (frame_abort) begin
            abort_cnt++;
            checks++;
            if (abort_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_abort: got frame_abort=1, expected none");
            end else begin
               void'(abort_q.pop_front());
            end
         end
      end
      prev_rd = fifo_rd_en;
   end

   task automatic load(input int base, input bit expect_frame);
      frame_t e;
      e.data = '0;
      for (int k = 0; k < N_LED; k++) begin
         mem[wr_ptr] = DW'(base + k);
         wr_ptr++;
         e.data[k*DW +: DW] = DW'(base + k);
      end
      if (expect_frame) begin
         exp_cnt = exp_cnt + 1'b1;
         e.cnt   = exp_cnt;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_upd(input string name, input int budget);
      int start, n;
      start = upd_cnt;
      n = 0;
      while (upd_cnt == start && n < budget) begin
         @(negedge clk); n++;
      end
      if (upd_cnt == start) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no frame_upd in %0d cycles, expected one", name, budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      wr_ptr = rd_ptr;
      exp_cnt = '0;
      last_frame = '0;
      #1;
      chk("rst_async_rd_en", N_LED*DW'(fifo_rd_en), '0);
      chk("rst_async_data", frame_data, '0);
      chk("rst_async_idx", N_LED*DW'(led_idx), '0);
      chk("rst_async_cnt", N_LED*DW'(frame_cnt), '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int first_upd, n, r0, u0;
      rst = 1'b1;
      drv_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rd_en", N_LED*DW'(fifo_rd_en), '0);
      chk("reset_data", frame_data, '0);
      chk("reset_upd_abort", N_LED*DW'({frame_upd, frame_abort}), '0);
      chk("reset_idx_cnt", N_LED*DW'({led_idx, frame_cnt}), '0);

      // Normal frame: preloaded FIFO, commit expected after edge 121.
      load(0, 1'b1);
      rst = 1'b0;
      first_upd = 0;
      r0 = rd_cnt;
      for (n = 1; n <= 125; n++) begin
         @(negedge clk);
         if (frame_upd && first_upd == 0) first_upd = n;
      end
      chk("normal_upd_cycle", N_LED*DW'(first_upd), N_LED*DW'(121));
      chk("normal_rd_pulses", N_LED*DW'(rd_cnt - r0), N_LED*DW'(40));

      // Deferred commit while the driver is mid-scan.
      drv_busy = 1'b1;
      r0 = rd_cnt;
      load(0, 1'b1);
      n = 0;
      while (rd_cnt - r0 < 40 && n < 300) begin @(negedge clk); n++; end
      chk("defer_rd_pulses", N_LED*DW'(rd_cnt - r0), N_LED*DW'(40));
      repeat (2) @(negedge clk);
      r0 = rd_cnt; u0 = upd_cnt;
      repeat (100) @(negedge clk);
      chk("defer_no_upd", N_LED*DW'(upd_cnt - u0), '0);
      chk("defer_no_rd", N_LED*DW'(rd_cnt - r0), '0);
      drv_busy = 1'b0;
      @(negedge clk);
      chk("defer_upd_next", N_LED*DW'(frame_upd), N_LED*DW'(1));

      // Underrun: 10 bytes, then FIFO stays empty past the timeout.
      u0 = abort_cnt;
      for (int k = 0; k < 10; k++) begin mem[wr_ptr] = DW'(90 + k); wr_ptr++; end
      abort_q.push_back(1);
      n = 0;
      while (abort_cnt == u0 && n < TIMEOUT + 200) begin @(negedge clk); n++; end
      chk("underrun_abort", N_LED*DW'(abort_cnt - u0), N_LED*DW'(1));
      chk("underrun_idx", N_LED*DW'(led_idx), '0);
      chk("underrun_data_kept", frame_data, last_frame);
      load(100, 1'b1);
      wait_upd("underrun_next", 200);

      // Reset in the middle of a frame.
      load(50, 1'b0);
      n = 0;
      while (led_idx != IW'(20) && n < 200) begin @(negedge clk); n++; end
      chk("midframe_reach20", N_LED*DW'(led_idx), N_LED*DW'(20));
      do_reset();
      #1 chk("release_rd_en", N_LED*DW'(fifo_rd_en), '0);
      load(200, 1'b1);
      wait_upd("midreset_next", 200);

      // Counter wrap with a 2-bit frame counter: 1,2,3,0,1.
      do_reset();
      for (int f = 0; f < 5; f++) begin
         load(f * 17 + 3, 1'b1);
         wait_upd("wrap", 200);
      end

      repeat (5) @(negedge clk);
      chk("exp_queue_drained", N_LED*DW'(exp_q.size()), '0);
      chk("abort_queue_drained", N_LED*DW'(abort_q.size()), '0);
      chk("protocol_rules", N_LED*DW'(rule_viol), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected completion");
      $fatal(1, "time limit");
   end

endmodule
